// File: rtl/par_traffic_source_pkg.sv
// Packet format and helpers shared by traffic sources, pkt_fifo users and the sink stage.
package par_traffic_source_pkg;
   localparam int HDR_SZ  = 4;
   localparam int PL_SZ   = 8;
   localparam int ADDR_SZ = 4;
   localparam int PKT_W   = HDR_SZ + PL_SZ + ADDR_SZ;

   // Field slices within a flat packet word: {hdr, payload, addr}
   localparam int ADDR_LO = 0;
   localparam int ADDR_HI = ADDR_SZ - 1;
   localparam int PL_LO   = ADDR_SZ;
   localparam int PL_HI   = ADDR_SZ + PL_SZ - 1;
   localparam int HDR_LO  = ADDR_SZ + PL_SZ;
   localparam int HDR_HI  = PKT_W - 1;

   typedef struct packed {
      logic [HDR_SZ-1:0]  hdr;
      logic [PL_SZ-1:0]   payload;
      logic [ADDR_SZ-1:0] addr;
   } pkt_t;

   // Galois LFSR step for x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
   endfunction
endpackage

// File: rtl/pkt_fifo.sv
// Small circular packet FIFO; writes ignored when full, reads ignored when empty.
module pkt_fifo #(
   parameter int depth = 4,
   parameter int width = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [width-1:0]         din,
   output logic [width-1:0]         dout,
   output logic [$clog2(depth):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             wr_en, rd_en;

   assign full  = (count == (PW+1)'(depth));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // Storage is cleared on reset so the output word reads zero afterwards
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < depth; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(wr_en) - (PW+1)'(rd_en);
      end
   end
endmodule

// File: rtl/par_traffic_source.sv
// LFSR-paced packet injector with a back-pressure FIFO feeding a req/busy sink.
module par_traffic_source
   import par_traffic_source_pkg::*;
#(
   parameter int         id    = 0,
   parameter int         rate  = 128,
   parameter int         dest  = -1,
   parameter logic [7:0] seed  = 8'hA5,
   parameter int         depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             channel_busy,
   output logic [PKT_W-1:0] item_out,
   output logic             valid,
   output logic [15:0]      sent_count,
   output logic [15:0]      drop_count
);
   logic [7:0]            lfsr;
   logic [PL_SZ-1:0]      seq;
   logic                  gen, push, pop, drop, full, empty;
   logic [$clog2(depth):0] fifo_count;
   pkt_t                  pkt;

   // rate spans 0..256, so the compare needs a ninth bit
   assign gen  = enable && ({1'b0, lfsr} < 9'(rate));
   assign push = gen && !full;
   assign drop = gen && full;
   assign pop  = !empty && !channel_busy;

   assign pkt.hdr     = HDR_SZ'(id);
   assign pkt.payload = seq;
   assign pkt.addr    = (dest == -1) ? lfsr[ADDR_SZ-1:0] : ADDR_SZ'(dest);

   assign valid = (fifo_count != '0);

   pkt_fifo #(.depth(depth), .width(PKT_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pkt),
      .dout  (item_out),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr       <= seed;
         seq        <= '0;
         sent_count <= '0;
         drop_count <= '0;
      end else begin
         lfsr <= lfsr_next(lfsr);
         if (push) seq <= seq + PL_SZ'(1);
         if (pop && sent_count != 16'hFFFF) sent_count <= sent_count + 16'd1;
         if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_par_traffic_source.sv
// Directed and scoreboard checks of par_traffic_source in three parameterisations.
module tb_par_traffic_source;
   localparam int W = 16;

   logic clk = 0, reset = 1;
   always #5 clk = ~clk;

   logic a_en = 0, a_busy = 0, r_en = 0, r_busy = 0, z_en = 1, z_busy = 0;
   logic [W-1:0] a_item, r_item, z_item;
   logic a_v, r_v, z_v;
   logic [15:0] a_sent, a_drop, r_sent, r_drop, z_sent, z_drop;

   par_traffic_source #(.id(2), .rate(256), .dest(3), .depth(4)) u_a (
      .clk(clk), .reset(reset), .enable(a_en), .channel_busy(a_busy),
      .item_out(a_item), .valid(a_v), .sent_count(a_sent), .drop_count(a_drop));
   par_traffic_source #(.id(1), .rate(128), .dest(-1), .depth(4)) u_r (
      .clk(clk), .reset(reset), .enable(r_en), .channel_busy(r_busy),
      .item_out(r_item), .valid(r_v), .sent_count(r_sent), .drop_count(r_drop));
   par_traffic_source #(.id(0), .rate(0), .depth(4)) u_z (
      .clk(clk), .reset(reset), .enable(z_en), .channel_busy(z_busy),
      .item_out(z_item), .valid(z_v), .sent_count(z_sent), .drop_count(z_drop));

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model for u_r, stepped once per clock edge
   logic [7:0]   m_lfsr;
   logic [7:0]   m_seq;
   int           m_sent, m_drop, m_gen;
   logic [W-1:0] mq[$];

   function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
      logic [7:0] n;
      n = {1'b0, s[7:1]};
      if (s[0]) n = n ^ 8'b1011_1000;
      return n;
   endfunction

   task automatic model_reset();
      m_lfsr = 8'hA5; m_seq = 0; m_sent = 0; m_drop = 0; m_gen = 0; mq.delete();
   endtask

   task automatic model_step();
      logic g, p, f;
      g = r_en && (m_lfsr < 8'd128);
      p = (mq.size() != 0) && !r_busy;
      f = (mq.size() == 4);
      if (p) begin void'(mq.pop_front()); m_sent++; end
      if (g) begin
         m_gen++;
         if (f) m_drop++;
         else begin mq.push_back({4'd1, m_seq, m_lfsr[3:0]}); m_seq++; end
      end
      m_lfsr = ref_lfsr(m_lfsr);
   endtask

   task automatic step();
      if (reset) model_reset(); else model_step();
      @(posedge clk); #1;
   endtask

   logic z_seen = 0;
   always @(negedge clk) if (z_v) z_seen = 1;

   typedef struct {
      logic en, busy, v, chk_pl;
      logic [7:0] pl;
      logic [15:0] sent, drop;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input logic en, busy, v, chk_pl, input int pl, sent, drop);
      vec_t x;
      x.en = en; x.busy = busy; x.v = v; x.chk_pl = chk_pl;
      x.pl = 8'(pl); x.sent = 16'(sent); x.drop = 16'(drop);
      return x;
   endfunction

   initial begin
      logic [W-1:0] prev_item;
      logic prev_v, busy_applied;

      for (int k = 1; k <= 9; k++) vecs.push_back(mk(1, 0, 1, 1, k-1, k-1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 1, 1, 1, 9, 9, 0));
      for (int k = 1; k <= 4; k++) vecs.push_back(mk(1, 1, 1, 1, 9, 9, k));
      vecs.push_back(mk(1, 0, 1, 1, 10, 10, 5));   // full + pop: still a drop
      for (int k = 11; k <= 14; k++) vecs.push_back(mk(1, 0, 1, 1, k, k, 5));
      vecs.push_back(mk(0, 0, 1, 1, 15, 15, 5));
      vecs.push_back(mk(0, 0, 1, 1, 16, 16, 5));
      vecs.push_back(mk(0, 0, 0, 0, 0, 17, 5));

      repeat (3) step();
      chk("reset_valid", a_v, 0);
      chk("reset_item", a_item, 0);
      chk("reset_sent", a_sent, 0);
      chk("reset_drop", a_drop, 0);
      @(negedge clk); reset = 0;
      @(posedge clk); #1;
      model_reset();

      foreach (vecs[i]) begin
         a_en = vecs[i].en; a_busy = vecs[i].busy;
         step();
         chk($sformatf("v%0d_valid", i), a_v, vecs[i].v);
         if (vecs[i].chk_pl)
            chk($sformatf("v%0d_item", i), a_item, {4'd2, vecs[i].pl, 4'd3});
         chk($sformatf("v%0d_sent", i), a_sent, vecs[i].sent);
         chk($sformatf("v%0d_drop", i), a_drop, vecs[i].drop);
      end

      // Queue three packets, then reset between edges
      a_en = 1; a_busy = 1;
      repeat (3) step();
      chk("preq_item", a_item, {4'd2, 8'd17, 4'd3});
      #3 reset = 1;
      #1;
      model_reset();
      chk("midrst_valid", a_v, 0);
      chk("midrst_sent", a_sent, 0);
      chk("midrst_drop", a_drop, 0);
      @(negedge clk); reset = 0;
      a_en = 1; a_busy = 0;
      step();
      chk("post_rst_valid", a_v, 1);
      chk("post_rst_item", a_item, {4'd2, 8'd0, 4'd3});
      a_en = 0;
      step();
      chk("post_rst_drain", a_v, 0);
      chk("post_rst_sent", a_sent, 1);

      // Random back-pressure on the LFSR-paced, LFSR-addressed source
      r_en = 1;
      prev_v = r_v; prev_item = r_item;
      for (int c = 0; c < 2000; c++) begin
         r_busy = ($urandom_range(0, 99) < 45);
         busy_applied = r_busy;
         step();
         chk("r_valid", r_v, mq.size() != 0);
         if (mq.size() != 0) chk("r_item", r_item, mq[0]);
         chk("r_sent", r_sent, m_sent);
         chk("r_drop", r_drop, m_drop);
         if (prev_v && busy_applied) chk("r_hold", r_item, prev_item);
         prev_v = r_v; prev_item = r_item;
      end
      chk("r_total", r_sent + r_drop + mq.size(), m_gen);

      chk("z_never_valid", z_seen, 0);
      chk("z_sent", z_sent, 0);
      chk("z_drop", z_drop, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/par_traffic_source.md
Name: par_traffic_source

Overview:
- Packet injector that sits directly upstream of the sink stage. It drives the sink's item_in and valid inputs and obeys its channel_busy output.
- Generates packets under an LFSR-controlled injection rate. Payload is a sequence number; the header carries the source id; the address field carries the destination.
- A small FIFO absorbs back-pressure. Packets are dropped, and counted, only when the FIFO is full.

Parameters:
- id, 0: source id; low HDR_SZ bits are placed in the header field.
- rate, 128: injection threshold, range 0..256. Inject when lfsr < rate. 0 = never inject, 256 = inject every enabled cycle.
- dest, -1: fixed destination address. -1 = take lfsr[ADDR_SZ-1:0] each generated packet.
- seed, 8'hA5: LFSR reset value; must be nonzero.
- depth, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  generation enable; draining continues when low.
- channel_busy  in  1  busy from downstream sink.
- item_out  out  HDR_SZ+PL_SZ+ADDR_SZ  packet {hdr, payload, addr}; hdr in the MSBs, addr in the LSBs.
- valid  out  1  item_out holds a packet.
- sent_count  out  16  packets accepted downstream; saturates at 16'hFFFF.
- drop_count  out  16  packets dropped on full FIFO; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high.
- Reset values: valid=0, item_out=0, sent_count=0, drop_count=0, FIFO empty (pointers 0, count 0), seq=0, lfsr=seed.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle after reset, independent of enable.
  - Never reaches 0, so values span 1..255.
- Generate condition: enable=1 and {1'b0,lfsr} < rate (9-bit compare), using the current lfsr value.
- Generated packet:
  - hdr = id[HDR_SZ-1:0]
  - payload = seq
  - addr = (dest == -1) ? lfsr[ADDR_SZ-1:0] : dest[ADDR_SZ-1:0]
- Push and drop:
  - If generate and count < depth (count taken before any same-cycle pop), write the packet at wr_ptr and increment seq. seq is PL_SZ bits and wraps to 0.
  - If generate and count == depth, drop the packet: increment drop_count and leave seq unchanged.
  - Full with a same-cycle pop still drops. The fullness decision uses the pre-pop count.
- Output:
  - valid = (count != 0), item_out = mem[rd_ptr]. Both are driven from registers only.
  - There is no combinational path from channel_busy or enable to any output.
- Handshake:
  - A transfer occurs at a rising edge where valid=1 and channel_busy=0. This matches the sink, which accepts on req & !busy.
  - On transfer: pop (rd_ptr++), sent_count++.
  - While valid=1 and channel_busy=1, item_out and valid hold stable.
- Latency: a packet generated in cycle N into an empty FIFO appears on valid/item_out in cycle N+1.
- Throughput: back-to-back transfers are allowed. valid stays high across consecutive pops while count > 1.
- Simultaneous push and pop (count not full): count unchanged, both pointers advance.
- Pointer wrap: log2(depth)-bit pointers wrap naturally. count is log2(depth)+1 bits.
- Reset mid-operation: queued packets are discarded. valid falls asynchronously with reset.
- Simulation: when id != -1, print "##,tx,id,payload" on each transfer.

Decomposition:
- Shared defines header: HDR_SZ, PL_SZ, ADDR_SZ and the packet field slice macros (hdr/payload/addr ranges). The sink stage uses the same header.
- Sub-module pkt_fifo (depth, width). Its ports are push, pop, din, dout, count, full and empty. It is reusable by other sources and routers.
- LFSR stays inline.

Test Plan:
- rate=256, dest=3, id=2, channel_busy=0, enable=1 for 10 cycles -> valid high from cycle 2, payloads 0..8 in order, addr=3, hdr=2, drop_count=0.
- rate=256, depth=4, channel_busy=1 for 8 enabled cycles -> count=4, item_out payload stays 0, drop_count=4. Release busy -> payloads 0,1,2,3,4... with no gaps in sent order.
- rate=0 for 300 cycles -> valid never asserts; sent_count=drop_count=0.
- Full FIFO with channel_busy=0 on the same cycle as generate -> that packet is dropped (drop_count+1), one pop occurs, and seq is not advanced.
- Assert reset mid-stream with 3 packets queued -> valid=0 and counters=0 immediately. After release, the first payload is 0 and lfsr restarts at seed.
- dest=-1, rate=128, random channel_busy for 2000 cycles -> no item_out change while valid&busy. sent_count + drop_count + count equals the generated total, cross-checked against a scoreboard LFSR model.
